dma_controller: RTL and testbench

Two-channel fly-by DMA controller for the shared 8-bit system bus (AB address, DB data, CB control = IOR|IOW|MEMR|MEMW). It takes bus ownership from the CPU with a HOLD/HLDA handshake and drives AB and CB for single-byte transfers between memory and an I/O device. The memory drives or samples DB itself; the controller never touches DB. Each channel's start address, count and mode are loaded through a dedicated configuration port.

---
 rtl/dma_controller.sv | 154 +++++++++++++++
 tb/tb_dma_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller: two-channel fly-by DMA for the shared 8-bit system bus.
// Acquires the bus from the CPU through HOLD/HLDA. Drives AB/CB for one
// byte per grant, stepping the channel address and count after each byte.
// The data bus is left to memory and the I/O device.
module dma_controller (
  input  logic       CLK,
  input  logic       RST,
  inout  wire  [7:0] AB,
  inout  wire  [3:0] CB,
  input  logic [1:0] DREQ,
  output logic [1:0] DACK,
  output logic       HOLD,
  input  logic       HLDA,
  input  logic       CFG_WE,
  input  logic [2:0] CFG_ADDR,
  input  logic [7:0] CFG_DATA,
  output logic [1:0] TC,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HREQ   = 2'd1,
    ST_XFER   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t          state_r;
  logic            ch_r;
  logic            hold_r;
  logic            busy_r;
  logic [1:0]      dack_r;
  logic [1:0][7:0] addr_r;
  logic [1:0][7:0] count_r;
  logic [1:0][2:0] mode_r;   // {DEC, DIR, EN}
  logic [1:0]      tc_r;

  logic [1:0]      elig_s;
  logic            win_s;
  logic            drive_s;
  logic [3:0]      cb_s;
  logic            cfg_ch_s;
  logic            lock_s;

  // Request arbitration, bus-drive qualification and config lockout decode
  always_comb begin
    elig_s = DREQ & {mode_r[1][0], mode_r[0][0]};
    if (elig_s[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
    // HLDA gates the drivers directly so a lost grant frees the bus at once
    drive_s = (state_r == ST_XFER) && HLDA;
    if (mode_r[ch_r][1]) begin
      cb_s = 4'b1001;          // IOR + MEMW : io -> mem
    end else begin
      cb_s = 4'b0110;          // IOW + MEMR : mem -> io
    end
    cfg_ch_s = CFG_ADDR[2];
    // the channel being serviced must not change under the transfer
    lock_s   = busy_r && (cfg_ch_s == ch_r);
  end

  assign AB   = drive_s ? addr_r[ch_r] : 8'hzz;
  assign CB   = drive_s ? cb_s         : 4'hz;
  assign HOLD = hold_r;
  assign DACK = dack_r;
  assign BUSY = busy_r;
  assign TC   = tc_r;

  // Bus-ownership sequencer with registered HOLD/DACK/BUSY
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      ch_r    <= 1'b0;
      hold_r  <= 1'b0;
      busy_r  <= 1'b0;
      dack_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // wait for the CPU to have dropped the previous grant
          if (!HLDA && (elig_s != 2'b00)) begin
            ch_r    <= win_s;
            state_r <= ST_HREQ;
            hold_r  <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        ST_HREQ: begin
          if (HLDA) begin
            state_r <= ST_XFER;
            dack_r  <= ch_r ? 2'b10 : 2'b01;
          end
        end
        ST_XFER: begin
          dack_r <= 2'b00;
          if (HLDA) begin
            state_r <= ST_UPDATE;
            hold_r  <= 1'b0;
          end else begin
            // grant lost mid-byte: re-request and retry the same byte
            state_r <= ST_HREQ;
          end
        end
        ST_UPDATE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          hold_r  <= 1'b0;
          busy_r  <= 1'b0;
          dack_r  <= 2'b00;
        end
      endcase
    end
  end

  // Channel registers: config writes, post-byte address/count step, TC
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_r  <= '0;
      count_r <= '0;
      mode_r  <= '0;
      tc_r    <= 2'b00;
    end else begin
      if (CFG_WE) begin
        case (CFG_ADDR[1:0])
          2'd0: if (!lock_s) addr_r[cfg_ch_s]  <= CFG_DATA;
          2'd1: if (!lock_s) count_r[cfg_ch_s] <= CFG_DATA;
          2'd2: if (!lock_s) mode_r[cfg_ch_s]  <= CFG_DATA[2:0];
          2'd3: tc_r <= tc_r & ~CFG_DATA[1:0];
          default: ;
        endcase
      end
      // placed after the config write so a same-edge TC set beats a clear
      if (state_r == ST_UPDATE) begin
        if (mode_r[ch_r][2]) begin
          addr_r[ch_r] <= addr_r[ch_r] - 8'd1;
        end else begin
          addr_r[ch_r] <= addr_r[ch_r] + 8'd1;
        end
        count_r[ch_r] <= count_r[ch_r] - 8'd1;
        if (count_r[ch_r] == 8'd0) begin
          tc_r[ch_r]      <= 1'b1;
          mode_r[ch_r][0] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: CPU grant model, memory and I/O device
// on a private data bus, transfer monitor, hand-computed expectations.
module tb_dma_controller;

  logic       CLK = 1'b0;
  logic       RST;
  wire  [7:0] AB;
  wire  [3:0] CB;
  logic [1:0] DREQ;
  logic [1:0] DACK;
  logic       HOLD;
  logic       HLDA;
  logic       CFG_WE;
  logic [2:0] CFG_ADDR;
  logic [7:0] CFG_DATA;
  logic [1:0] TC;
  logic       BUSY;

  int tests_run = 0;
  int fails     = 0;

  // CPU: grants immediately in auto mode, else follows hlda_man;
  // drives idle zeros on AB/CB whenever it owns the bus
  logic auto_grant;
  logic hlda_man;
  assign HLDA = auto_grant ? HOLD : hlda_man;
  assign AB   = HLDA ? 8'hzz : 8'h00;
  assign CB   = HLDA ? 4'hz  : 4'h0;

  dma_controller dut (
    .CLK(CLK), .RST(RST), .AB(AB), .CB(CB), .DREQ(DREQ), .DACK(DACK),
    .HOLD(HOLD), .HLDA(HLDA), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .TC(TC), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // memory (initialised to addr^3C on reset) and I/O device
  logic [7:0] mem [256];
  logic [7:0] io_val;
  logic [7:0] io_last;
  int         io_cnt = 0;
  logic [7:0] db;

  always_comb begin
    db = 8'h00;
    if (CB[1] === 1'b1)      db = mem[AB];
    else if (CB[3] === 1'b1) db = io_val;
  end

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else begin
      if (CB[0] === 1'b1) mem[AB] <= db;
      if (CB[2] === 1'b1) begin
        io_last <= db;
        io_cnt  <= io_cnt + 1;
      end
    end
  end

  // transfer monitor
  logic [7:0] q_ab[$];
  logic [3:0] q_cb[$];
  logic [1:0] q_dack[$];
  logic       hold_prev = 1'b0;
  int         hold_falls = 0;

  always @(negedge CLK) begin
    if (DACK != 2'b00 && HLDA) begin
      q_ab.push_back(AB);
      q_cb.push_back(CB);
      q_dack.push_back(DACK);
    end
    hold_prev <= HOLD;
    if (hold_prev && !HOLD) hold_falls <= hold_falls + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input int idx, input logic [7:0] ab,
                            input logic [3:0] cb, input logic [1:0] dk);
    check_eq({tag, "_ab"},   32'(q_ab[idx]),   32'(ab));
    check_eq({tag, "_cb"},   32'(q_cb[idx]),   32'(cb));
    check_eq({tag, "_dack"}, 32'(q_dack[idx]), 32'(dk));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; DREQ = 2'b00; CFG_WE = 1'b0; CFG_ADDR = 3'd0; CFG_DATA = 8'h00;
    auto_grant = 1'b1; hlda_man = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    CFG_WE = 1'b1; CFG_ADDR = a; CFG_DATA = d;
    tick();
    CFG_WE = 1'b0;
  endtask

  task automatic wait_tc(input logic [1:0] mask, input int max);
    for (int i = 0; i < max; i++) begin
      if (((TC & mask) == mask) && !BUSY) break;
      tick();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int h0;
    int c0;
    int nbusy;
    io_val = 8'h00;
    do_reset();

    // reset state
    check_eq("rst_hold", 32'(HOLD), 32'd0);
    check_eq("rst_dack", 32'(DACK), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_tc",   32'(TC),   32'd0);
    check_eq("rst_ab",   32'(AB),   32'h00);
    check_eq("rst_cb",   32'(CB),   32'h0);

    // ch0 mem->io, 3 bytes from 10, with cycle-exact timing of the first
    cfg_write(3'd0, 8'h10); cfg_write(3'd1, 8'h02); cfg_write(3'd2, 8'h01);
    b = q_ab.size(); h0 = hold_falls;
    DREQ = 2'b01;
    tick();
    check_eq("t_hreq_hold", 32'(HOLD), 32'd1);
    check_eq("t_hreq_dack", 32'(DACK), 32'd0);
    check_eq("t_hreq_busy", 32'(BUSY), 32'd1);
    tick();
    check_eq("t_xfer_dack", 32'(DACK), 32'd1);
    check_eq("t_xfer_ab",   32'(AB),   32'h10);
    check_eq("t_xfer_cb",   32'(CB),   32'h6);
    tick();
    check_eq("t_upd_hold", 32'(HOLD), 32'd0);
    check_eq("t_upd_busy", 32'(BUSY), 32'd1);
    tick();
    check_eq("t_idle_busy", 32'(BUSY), 32'd0);
    check_eq("t_idle_tc",   32'(TC),   32'd0);
    wait_tc(2'b01, 40);
    check_eq("c0_tc", 32'(TC), 32'd1);
    check_eq("c0_n",  32'(q_ab.size() - b), 32'd3);
    check_xfer("c0_x0", b,     8'h10, 4'b0110, 2'b01);
    check_xfer("c0_x1", b + 1, 8'h11, 4'b0110, 2'b01);
    check_xfer("c0_x2", b + 2, 8'h12, 4'b0110, 2'b01);
    check_eq("c0_holdfalls", 32'(hold_falls - h0), 32'd3);
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BUSY) nbusy++;
    end
    check_eq("c0_en_clr", 32'(nbusy), 32'd0);
    cfg_write(3'd3, 8'h01);
    check_eq("tc_clear", 32'(TC), 32'd0);

    // ch1 io->mem, decrement, single byte at 05
    DREQ = 2'b00; io_val = 8'hA5;
    cfg_write(3'd4, 8'h05); cfg_write(3'd5, 8'h00); cfg_write(3'd6, 8'h07);
    b = q_ab.size();
    DREQ = 2'b10;
    wait_tc(2'b10, 30);
    check_eq("c1_tc", 32'(TC), 32'd2);
    check_eq("c1_n",  32'(q_ab.size() - b), 32'd1);
    check_xfer("c1_x0", b, 8'h05, 4'b1001, 2'b10);
    check_eq("c1_mem5", 32'(mem[5]), 32'hA5);

    // priority: ch0 drains before ch1
    do_reset();
    cfg_write(3'd0, 8'h20); cfg_write(3'd1, 8'h01); cfg_write(3'd2, 8'h01);
    cfg_write(3'd4, 8'h40); cfg_write(3'd5, 8'h00); cfg_write(3'd6, 8'h01);
    b = q_ab.size();
    DREQ = 2'b11;
    wait_tc(2'b11, 60);
    check_eq("pr_tc", 32'(TC), 32'd3);
    check_eq("pr_n",  32'(q_ab.size() - b), 32'd3);
    check_xfer("pr_x0", b,     8'h20, 4'b0110, 2'b01);
    check_xfer("pr_x1", b + 1, 8'h21, 4'b0110, 2'b01);
    check_xfer("pr_x2", b + 2, 8'h40, 4'b0110, 2'b10);

    // late grant, grant dropped during XFER, retry
    do_reset();
    auto_grant = 1'b0; hlda_man = 1'b0;
    cfg_write(3'd0, 8'h30); cfg_write(3'd1, 8'h00); cfg_write(3'd2, 8'h01);
    c0 = io_cnt;
    DREQ = 2'b01;
    tick();
    check_eq("hl_hold", 32'(HOLD), 32'd1);
    tick(); tick(); tick();
    check_eq("hl_wait_dack", 32'(DACK), 32'd0);
    check_eq("hl_wait_hold", 32'(HOLD), 32'd1);
    hlda_man = 1'b1;
    tick();
    check_eq("hl_xfer_dack", 32'(DACK), 32'd1);
    check_eq("hl_xfer_ab",   32'(AB),   32'h30);
    hlda_man = 1'b0;
    #1;
    check_eq("hl_drop_ab", 32'(AB), 32'h00);
    check_eq("hl_drop_cb", 32'(CB), 32'h0);
    tick();
    check_eq("hl_rereq_dack", 32'(DACK), 32'd0);
    check_eq("hl_rereq_hold", 32'(HOLD), 32'd1);
    hlda_man = 1'b1;
    tick();
    check_eq("hl_retry_ab",   32'(AB),   32'h30);
    check_eq("hl_retry_dack", 32'(DACK), 32'd1);
    tick();
    check_eq("hl_upd_hold", 32'(HOLD), 32'd0);
    hlda_man = 1'b0;
    tick();
    check_eq("hl_tc",     32'(TC),   32'd1);
    check_eq("hl_busy",   32'(BUSY), 32'd0);
    check_eq("hl_io_cnt", 32'(io_cnt - c0), 32'd1);
    check_eq("hl_io_dat", 32'(io_last), 32'h0C);
    auto_grant = 1'b1;

    // address wrap, lockout of serviced channel, other channel writable
    do_reset();
    cfg_write(3'd0, 8'hFF); cfg_write(3'd1, 8'h01); cfg_write(3'd2, 8'h01);
    b = q_ab.size();
    DREQ = 2'b01;
    tick();
    cfg_write(3'd0, 8'h80);
    cfg_write(3'd4, 8'h55);
    wait_tc(2'b01, 40);
    check_eq("wr_n", 32'(q_ab.size() - b), 32'd2);
    check_xfer("wr_x0", b,     8'hFF, 4'b0110, 2'b01);
    check_xfer("wr_x1", b + 1, 8'h00, 4'b0110, 2'b01);
    DREQ = 2'b00;
    cfg_write(3'd5, 8'h00); cfg_write(3'd6, 8'h01);
    DREQ = 2'b10;
    wait_tc(2'b10, 30);
    check_xfer("wr_c1", b + 2, 8'h55, 4'b0110, 2'b10);

    // reset during XFER
    do_reset();
    cfg_write(3'd4, 8'h70); cfg_write(3'd5, 8'h00); cfg_write(3'd6, 8'h01);
    DREQ = 2'b10;
    wait_tc(2'b10, 30);
    check_eq("rm_pre_tc", 32'(TC), 32'd2);
    cfg_write(3'd0, 8'h60); cfg_write(3'd1, 8'h05); cfg_write(3'd2, 8'h01);
    DREQ = 2'b01;
    for (int i = 0; i < 10; i++) begin
      if (DACK != 2'b00) break;
      tick();
    end
    check_eq("rm_pre_dack", 32'(DACK), 32'd1);
    RST = 1'b1;
    #1;
    check_eq("rm_hold", 32'(HOLD), 32'd0);
    check_eq("rm_dack", 32'(DACK), 32'd0);
    check_eq("rm_busy", 32'(BUSY), 32'd0);
    check_eq("rm_tc",   32'(TC),   32'd0);
    check_eq("rm_ab",   32'(AB),   32'h00);
    check_eq("rm_cb",   32'(CB),   32'h0);
    tick();
    RST = 1'b0;
    DREQ = 2'b11;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (BUSY) nbusy++;
    end
    check_eq("rm_en_zero", 32'(nbusy), 32'd0);
    // only MODE programmed: address and count must come back as 0
    DREQ = 2'b00;
    cfg_write(3'd2, 8'h01);
    b = q_ab.size();
    DREQ = 2'b01;
    wait_tc(2'b01, 30);
    check_eq("rm_n", 32'(q_ab.size() - b), 32'd1);
    check_xfer("rm_x0", b, 8'h00, 4'b0110, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
